// File: rtl/ram_clr.sv
// Single-port RAM that zeroes itself one word per cycle after reset or clr_i.
// Reads are registered. A write and read in the same cycle return the new data.
module ram_clr #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic [DATA_W-1:0] in_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] out_o,
  output logic              valid_o,
  output logic              busy_o
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_d;
  logic              rd;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mem_we   = 1'b0;
    mem_a    = address_i;
    mem_d    = in_i;
    rd       = 1'b0;
    unique case (state)
      CLEAR: begin
        mem_we = 1'b1;
        mem_a  = cnt;
        mem_d  = '0;
        if (clr_i) begin
          cnt_nx = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
          if (cnt == '1) state_nx = IDLE;
        end
      end
      IDLE: begin
        if (clr_i) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end else begin
          mem_we = we_i;
          rd     = re_i;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Array is deliberately not reset; the CLEAR walk zeroes it.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_a] <= mem_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_o   <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= rd;
      if (rd) out_o <= mem_we ? in_i : mem[address_i];
    end
  end

  assign busy_o = (state == CLEAR);

endmodule
